// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the two-layer inference sequencer.
// NN_SEQ_TIMEOUT_EN adds the ERR state used by the wait-state watchdog.
package nn_seq_pkg;

  localparam int unsigned AW1    = 18;  // weight1 SRAM address
  localparam int unsigned AW2    = 12;  // weight2 SRAM address
  localparam int unsigned AW3    = 10;  // input SRAM address
  localparam int unsigned AW4    = 6;   // output SRAM address
  localparam int unsigned AW5    = 7;   // sigmoid LUT address
  localparam int unsigned CNT_W  = 18;  // sweep counter width
  localparam int unsigned WAIT_W = 10;  // wait-state watchdog width
  localparam int unsigned NLANES = 10;

  localparam logic [NLANES-1:0] SIG_ALL = 10'h3FF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_L1_RUN,
    S_L1_WAIT,
    S_SIG1,
    S_L2_RUN,
    S_L2_WAIT,
    S_SIG2,
    S_WRITE
`ifdef NN_SEQ_TIMEOUT_EN
    , S_ERR
`endif
  } state_e;

endpackage

// File: rtl/nn_seq_sweep.sv
// Address sweep for one layer: presents 0..LEN-1 one per cycle, a start gate
// lagging the address by one cycle (SRAM read latency) and a last flag.
module nn_seq_sweep
  import nn_seq_pkg::*;
#(
  parameter int unsigned LEN = 784,
  parameter int unsigned AW  = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          en_i,
  output logic [AW-1:0] addr_o,
  output logic          gate_o,
  output logic          last_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             valid_q, valid_d;
  logic             gate_q, gate_d;
  logic             fin_q, fin_d;
  logic             last_q, last_d;

  // Next-state: counter stops at LEN-1, address is zero when not presenting.
  always_comb begin
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    addr_d  = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    gate_d  = valid_q;
    if (clear_i) begin
      cnt_d  = '0;
      fin_d  = 1'b0;
      gate_d = 1'b0;
    end else if (en_i && !fin_q) begin
      addr_d  = cnt_q[AW-1:0];
      valid_d = 1'b1;
      if (cnt_q == LAST) begin
        fin_d  = 1'b1;
        last_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sweep state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      gate_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      gate_q  <= gate_d;
      last_q  <= last_d;
    end
  end

  assign addr_o = addr_q;
  assign gate_o = gate_q;
  assign last_o = last_q;

endmodule

// File: rtl/nn_sequencer.sv
// Control FSM for the two-layer MAC/sigmoid inference datapath.
// Optional: define NN_SEQ_TIMEOUT_EN to enable the wait-state watchdog and ERR.
module nn_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned L1_LEN  = 784,
  parameter int unsigned L2_LEN  = 10,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              abort,
  input  logic [AW4-1:0]    out_slot,
  input  logic              host_we,
  input  logic [AW1-1:0]    host_addr,
  output logic              we,
  output logic              out_we,
  output logic [AW1-1:0]    address_1,
  output logic [AW2-1:0]    address_2,
  output logic [AW3-1:0]    address_3,
  output logic [AW4-1:0]    address_4,
  output logic [AW5-1:0]    address_5,
  output logic              mac1_start,
  output logic              mac2_start,
  input  logic              mac1_done,
  input  logic              mac2_done,
  input  logic [NLANES-1:0] sig1_ready,
  input  logic [NLANES-1:0] sig2_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e         state_q, state_d;
  logic [AW4-1:0] slot_q, slot_d;
  logic [AW4-1:0] a4_q, a4_d;
  logic [AW1-1:0] haddr_q, haddr_d;
  logic           hwe_q, hwe_d;
  logic           out_we_q, out_we_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [AW1-1:0] s1_addr;
  logic [AW2-1:0] s2_addr;
  logic           s1_last, s2_last;

`ifdef NN_SEQ_TIMEOUT_EN
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  nn_seq_sweep #(.LEN(L1_LEN), .AW(AW1)) u_sweep1 (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (abort || (state_q != S_L1_RUN)),
    .en_i    (state_q == S_L1_RUN),
    .addr_o  (s1_addr),
    .gate_o  (mac1_start),
    .last_o  (s1_last)
  );

  nn_seq_sweep #(.LEN(L2_LEN), .AW(AW2)) u_sweep2 (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (abort || (state_q != S_L2_RUN)),
    .en_i    (state_q == S_L2_RUN),
    .addr_o  (s2_addr),
    .gate_o  (mac2_start),
    .last_o  (s2_last)
  );

  // Next state and next registered outputs; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    done_d   = 1'b0;
    out_we_d = 1'b0;
    a4_d     = '0;
    hwe_d    = 1'b0;
    haddr_d  = '0;
`ifdef NN_SEQ_TIMEOUT_EN
    err_d    = err_q;
    wait_d   = '0;
`endif
    case (state_q)
      S_IDLE: if (go) begin
        state_d = S_L1_RUN;
        slot_d  = out_slot;
      end
      S_L1_RUN:  if (s1_last)              state_d = S_L1_WAIT;
      S_L1_WAIT: if (mac1_done)            state_d = S_SIG1;
      S_SIG1:    if (sig1_ready == SIG_ALL) state_d = S_L2_RUN;
      S_L2_RUN:  if (s2_last)              state_d = S_L2_WAIT;
      S_L2_WAIT: if (mac2_done)            state_d = S_SIG2;
      S_SIG2:    if (sig2_ready == SIG_ALL) state_d = S_WRITE;
      S_WRITE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
`ifdef NN_SEQ_TIMEOUT_EN
      S_ERR: if (go) begin
        state_d = S_L1_RUN;
        slot_d  = out_slot;
        err_d   = 1'b0;
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef NN_SEQ_TIMEOUT_EN
    // Watchdog only advances while a wait state holds; any transition clears it.
    if ((state_q == S_L1_WAIT || state_q == S_SIG1 ||
         state_q == S_L2_WAIT || state_q == S_SIG2) && state_d == state_q) begin
      if (wait_q == WAIT_LAST) begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
`endif

    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
`ifdef NN_SEQ_TIMEOUT_EN
      err_d   = 1'b0;
      wait_d  = '0;
`endif
    end

    busy_d = (state_d != S_IDLE);
`ifdef NN_SEQ_TIMEOUT_EN
    if (state_d == S_ERR) busy_d = 1'b0;
`endif

    if (state_d == S_WRITE) begin
      out_we_d = 1'b1;
      a4_d     = slot_d;
    end
    if (state_d == S_IDLE && !abort) begin
      hwe_d   = host_we;
      haddr_d = host_addr;
      a4_d    = host_addr[AW4-1:0];
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      a4_q     <= '0;
      haddr_q  <= '0;
      hwe_q    <= 1'b0;
      out_we_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef NN_SEQ_TIMEOUT_EN
      wait_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      a4_q     <= a4_d;
      haddr_q  <= haddr_d;
      hwe_q    <= hwe_d;
      out_we_q <= out_we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef NN_SEQ_TIMEOUT_EN
      wait_q   <= wait_d;
      err_q    <= err_d;
`endif
    end
  end

  // Host pass-through and sweep addresses are never nonzero together, so OR-merge.
  assign address_1 = haddr_q | s1_addr;
  assign address_2 = haddr_q[AW2-1:0] | s2_addr;
  assign address_3 = haddr_q[AW3-1:0] | s1_addr[AW3-1:0];
  assign address_4 = a4_q;
  assign address_5 = haddr_q[AW5-1:0];
  assign we        = hwe_q;
  assign out_we    = out_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef NN_SEQ_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: doc/nn_sequencer.md
# nn_sequencer

Control FSM for the two-layer MAC/sigmoid inference datapath. For one inference it:
- sweeps the input and layer-1 weight SRAM addresses and gates the layer-1 MAC bank;
- waits for MAC completion and all ten sigmoids;
- repeats the sweep for layer 2 with the layer-2 weight SRAM;
- writes the result into a host-selected output SRAM slot.

It replaces the host-driven address, write-enable and start inputs at the datapath top level.

## Interface
Parameters:
- L1_LEN, 784: layer-1 sweep length (input/weight1 words per inference), 1..1023
- L2_LEN, 10: layer-2 sweep length (weight2 words), 1..4095
- TIMEOUT, 1023: max cycles waiting on any done/ready event (only with NN_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- go  in  1  start one inference (sampled in IDLE/ERR)
- abort  in  1  synchronous abort to IDLE
- out_slot  in  6  output SRAM slot for this inference, captured on go
- host_we  in  1  host load write enable, passed through in IDLE only
- host_addr  in  18  host load address, passed through in IDLE only
- we  out  1  input/weight/LUT SRAM write enable
- out_we  out  1  output SRAM write enable
- address_1  out  18  weight1 SRAM address
- address_2  out  12  weight2 SRAM address
- address_3  out  10  input SRAM address
- address_4  out  6  output SRAM address
- address_5  out  7  sigmoid LUT address
- mac1_start, mac2_start  out  1  MAC bank gate
- mac1_done, mac2_done  in  1  MAC bank completion
- sig1_ready, sig2_ready  in  10  per-lane sigmoid ready
- busy  out  1  inference in progress
- done  out  1  one-cycle completion pulse
- err  out  1  timeout flag, sticky until next go

## Operation
- States and transitions:
  - IDLE → L1_RUN on go.
  - L1_RUN → L1_WAIT after L1_LEN addresses.
  - L1_WAIT → SIG1 on mac1_done.
  - SIG1 → L2_RUN when sig1_ready == 10'h3FF.
  - L2_RUN → L2_WAIT after L2_LEN addresses.
  - L2_WAIT → SIG2 on mac2_done.
  - SIG2 → WRITE when sig2_ready == 10'h3FF.
  - WRITE → IDLE with done = 1.
- IDLE pass-through: we = host_we, and every address port = host_addr truncated to its own width. out_we = 0.
- Outside IDLE: we = 0, address_5 = 0, and the unused address ports hold 0.
- L1_RUN:
  - address_3 = address_1 = k, for k = 0..L1_LEN-1, one per cycle.
  - mac1_start = 1 for exactly L1_LEN cycles, lagging the address by one cycle to match the one-cycle SRAM read latency.
- L2_RUN: address_2 = k, for k = 0..L2_LEN-1. mac2_start follows the same one-cycle-lag rule.
- WRITE: out_we = 1 and address_4 = the captured out_slot, for exactly one cycle.
- busy = 1 in every state except IDLE and ERR.
- go while busy is ignored. out_slot is sampled only together with an accepted go.
- Any done or ready input seen outside its wait state is ignored.
- abort:
  - Takes priority over all transitions.
  - Next cycle the state is IDLE and all outputs are at their reset values.
  - No done pulse is produced.
- Counters:
  - 18-bit sweep counter, cleared on every RUN entry; the terminal compare is against LEN-1.
  - No wrap-around: the counter never exceeds LEN-1.

## Timing
- All outputs are registered. Reset values: every output 0, state IDLE.
- go accepted at edge t:
  - address k appears at t+1+k;
  - mac1_start is high on cycles t+2 .. t+1+L1_LEN.
- Earliest L2_RUN entry is the cycle after sig1_ready is complete. L2 timing mirrors L1.
- Minimum latency from go to done: L1_LEN + L2_LEN + 7 cycles, with done/ready returned immediately.
- Asserting reset mid-operation clears the FSM and all outputs immediately. After release the block is in IDLE.

## Configuration
- NN_SEQ_TIMEOUT_EN defined:
  - A 10-bit wait counter runs in L1_WAIT, SIG1, L2_WAIT and SIG2, and is cleared on each state entry.
  - Reaching TIMEOUT moves the FSM to ERR: err = 1, busy = 0, no done pulse.
  - go in ERR clears err and starts a new inference.
- NN_SEQ_TIMEOUT_EN undefined:
  - Wait states wait indefinitely.
  - err is tied to 0, the ERR state is absent, and TIMEOUT is ignored.

## Structure
- Package nn_seq_pkg contains:
  - the state enum;
  - address width constants (18/12/10/6/7);
  - the lane count NLANES = 10;
  - the SIG_ALL = 10'h3FF constant.
- Sub-module nn_seq_sweep: a LEN-parameterised address counter with a one-cycle-lagged start gate and a last flag. It is instantiated twice, once for layer 1 and once for layer 2.

## Test plan
- L1_LEN=4, L2_LEN=3, go with out_slot=5, done/ready returned the cycle after each wait entry:
  - address_3 sequence 0,1,2,3; mac1_start high for 4 cycles, lagging by 1;
  - address_2 sequence 0,1,2;
  - one out_we cycle at address_4 = 5;
  - done exactly 14 cycles after go.
- IDLE with host_we=1 and host_addr=18'h3_0405: we = 1; address_3 = 10'h005; address_2 = 12'h405.
- sig1_ready = 10'h3FE held for 20 cycles, then 10'h3FF: remains in SIG1 throughout; L2_RUN starts the next cycle.
- go pulsed mid-L1_RUN, plus mac2_done pulsed during L1_WAIT: both ignored; the sequence is unchanged.
- abort during L2_WAIT, and separately reset asserted during L1_RUN: all outputs 0 the next cycle, no done pulse; a new go runs correctly.
- With NN_SEQ_TIMEOUT_EN, TIMEOUT=8, mac1_done never asserted: err = 1 and busy = 0 after 8 wait cycles; the next go clears err.
